bit_mem_ctrl: RTL and testbench

BIT_MEM_CTRL -- requirements
Module: bit_mem_ctrl

---
 rtl/bit_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_bit_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_mem_ctrl.sv
// bit_mem_ctrl: single-bit read / write / read-modify-write controller in
// front of a one-bit-wide memory. One request is serviced at a time. The
// memory-side strobes are Moore outputs, decoded from the registered state
// and the latched request only.
module bit_mem_ctrl #(
  parameter int ADDRWIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic                 req_data,
  output logic                 rsp_valid,
  output logic                 rsp_data,
  output logic                 rsp_err,
  output logic                 mem_cs,
  output logic                 mem_rw,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_din,
  input  logic                 mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RSP
  } state_t;

  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_SET   = 3'b010;
  localparam logic [2:0] OP_CLR   = 3'b011;
  localparam logic [2:0] OP_CPL   = 3'b100;

  state_t                 state;
  state_t                 state_next;
  logic [2:0]             op_q;
  logic [ADDRWIDTH-1:0]   addr_q;
  logic                   data_q;
  logic                   old_q;
  logic                   handshake;
  logic                   op_q_illegal;
  logic                   wr_value;

  // The controller is only open for a new request while idle and out of reset.
  always_comb begin
    req_ready = (state == IDLE) && rst_n;
    handshake = req_valid && req_ready;
    op_q_illegal = (op_q > OP_CPL);
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Capture the request on the handshake edge and hold it for the whole operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= 3'b000;
      addr_q <= '0;
      data_q <= 1'b0;
    end else if (handshake) begin
      op_q   <= req_op;
      addr_q <= req_addr;
      data_q <= req_data;
    end
  end

  // The memory presents read data on the negedge inside RD, so sample it on the edge leaving RD.
  always_ff @(posedge clk) begin
    if (!rst_n)            old_q <= 1'b0;
    else if (state == RD)  old_q <= mem_dout;
  end

  // Sequencing: WRITE goes straight to the write cycle, RMW ops and READ read first,
  // illegal ops skip the memory entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (req_op == OP_WRITE)    state_next = WR;
          else if (req_op > OP_CPL)  state_next = RSP;
          else                       state_next = RD;
        end
      end
      RD: begin
        if (op_q == OP_READ) state_next = RSP;
        else                 state_next = WR;
      end
      WR:      state_next = RSP;
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Value to store: plain write data, or the modified copy of the bit that was just read.
  always_comb begin
    wr_value = 1'b0;
    case (op_q)
      OP_WRITE: wr_value = data_q;
      OP_SET:   wr_value = 1'b1;
      OP_CLR:   wr_value = 1'b0;
      OP_CPL:   wr_value = ~old_q;
      default:  wr_value = 1'b0;
    endcase
  end

  // Moore output decode for both the memory port and the response port.
  always_comb begin
    mem_cs    = 1'b1;
    mem_rw    = 1'b1;
    mem_din   = 1'b0;
    mem_addr  = addr_q;
    rsp_valid = 1'b0;
    rsp_data  = 1'b0;
    rsp_err   = 1'b0;
    case (state)
      RD: begin
        mem_cs = 1'b0;
        mem_rw = 1'b1;
      end
      WR: begin
        mem_cs  = 1'b0;
        mem_rw  = 1'b0;
        mem_din = wr_value;
      end
      RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = op_q_illegal;
        if (op_q == OP_WRITE)  rsp_data = data_q;
        else if (!op_q_illegal) rsp_data = old_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bit_mem_ctrl.sv
// Self-checking bench for bit_mem_ctrl: a behavioural bit memory, a reference
// model that predicts each response and the final memory image, and a
// scoreboard monitor that checks responses as the DUT produces them.
module tb_bit_mem_ctrl;

  localparam int AW = 3;
  localparam int NBITS = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic          req_data;
  logic          rsp_valid;
  logic          rsp_data;
  logic          rsp_err;
  logic          mem_cs;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic          mem_din;
  logic          mem_dout;

  typedef struct {
    logic d;
    logic e;
    time  t;
    int   lat;
  } exp_t;

  exp_t              sb[$];
  logic [NBITS-1:0]  mem_bits;
  logic [NBITS-1:0]  ref_bits;
  int                total;
  int                bad;
  int                rd_cnt;
  int                wr_cnt;
  int                exp_rd;
  int                exp_wr;
  bit                have_prev;
  time               prev_t;
  int                prev_lat;

  bit_mem_ctrl #(.ADDRWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural bit memory: acts on the falling edge while selected.
  initial begin
    mem_bits = '0;
    mem_dout = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
  end
  always @(negedge clk) begin
    if (mem_cs === 1'b0) begin
      if (mem_rw) begin
        mem_dout = mem_bits[mem_addr];
        rd_cnt++;
      end else begin
        mem_bits[mem_addr] = mem_din;
        wr_cnt++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int latencyOf(input logic [2:0] op);
    case (op)
      3'b000, 3'b001:         return 2;
      3'b010, 3'b011, 3'b100: return 3;
      default:                return 1;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever a response appears, otherwise checks quiet outputs.
  always begin
    @(posedge clk);
    #1;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_data", 32'(rsp_data), 32'(e.d));
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.e));
        checkOutput("rsp_latency", 32'(($time - 1 - e.t) / 10 + 1), 32'(e.lat));
      end
    end else if (rst_n === 1'b1) begin
      checkOutput("rsp_quiet", {30'd0, rsp_data, rsp_err}, 32'd0);
    end
  end

  // Offer one request (req_valid stays high afterwards so the next call is back-to-back),
  // predict its outcome at the handshake edge, optionally abort it with reset in its first cycle.
  task automatic applyStimulus(input logic [2:0] op, input logic [AW-1:0] addr,
                               input logic d, input bit abort);
    int   waited;
    time  t;
    logic old;
    exp_t e;
    waited = 0;
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_data = d;
    @(negedge clk);
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      checkOutput("handshake_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      have_prev = 0;
      return;
    end
    @(posedge clk);
    t = $time;
    if (have_prev)
      checkOutput("throughput", 32'((t - prev_t) / 10), 32'(prev_lat + 1));
    old = ref_bits[addr];
    e.d = 1'b0;
    e.e = 1'b0;
    e.t = t;
    e.lat = latencyOf(op);
    case (op)
      3'b000: e.d = old;
      3'b001: e.d = d;
      3'b010, 3'b011, 3'b100: e.d = old;
      default: e.e = 1'b1;
    endcase
    if (op != 3'b001 && op <= 3'b100) exp_rd++;
    if (abort) begin
      #1;
      rst_n = 1'b0;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort_ready", 32'(req_ready), 32'd0);
      checkOutput("abort_cs", 32'(mem_cs), 32'd1);
      checkOutput("abort_rsp", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      have_prev = 0;
      repeat (4) @(posedge clk);
      #1;
      return;
    end
    if (op <= 3'b100 && op != 3'b000) exp_wr++;
    case (op)
      3'b001: ref_bits[addr] = d;
      3'b010: ref_bits[addr] = 1'b1;
      3'b011: ref_bits[addr] = 1'b0;
      3'b100: ref_bits[addr] = ~old;
      default: ;
    endcase
    sb.push_back(e);
    #1;
    checkOutput("ready_busy", 32'(req_ready), 32'd0);
    have_prev = 1;
    prev_t = t;
    prev_lat = e.lat;
  endtask

  // Watchdog so a stuck handshake or response can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset checks, directed scenarios, random traffic, final memory audit.
  initial begin
    total = 0;
    bad = 0;
    exp_rd = 0;
    exp_wr = 0;
    have_prev = 0;
    prev_t = 0;
    prev_lat = 0;
    ref_bits = '0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 3'b000;
    req_addr = '0;
    req_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp", {29'd0, rsp_valid, rsp_data, rsp_err}, 32'd0);
    checkOutput("reset_mem", {27'd0, mem_cs, mem_rw, mem_din, 2'b00}, 32'h18);
    checkOutput("reset_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", 32'(req_ready), 32'd1);
    checkOutput("cs_after_reset", 32'(mem_cs), 32'd1);
    @(posedge clk);
    #1;

    applyStimulus(3'b001, 3'd5, 1'b1, 0);
    applyStimulus(3'b000, 3'd5, 1'b0, 0);
    applyStimulus(3'b100, 3'd2, 1'b0, 0);
    applyStimulus(3'b000, 3'd2, 1'b0, 0);
    applyStimulus(3'b010, 3'd7, 1'b0, 0);
    applyStimulus(3'b011, 3'd7, 1'b1, 0);
    applyStimulus(3'b110, 3'd4, 1'b1, 0);
    applyStimulus(3'b111, 3'd1, 1'b0, 0);
    applyStimulus(3'b010, 3'd3, 1'b0, 1);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]    op;
      logic [AW-1:0] a;
      logic          d;
      op = 3'($urandom_range(0, 7));
      a  = AW'($urandom_range(0, NBITS - 1));
      d  = 1'($urandom_range(0, 1));
      applyStimulus(op, a, d, 0);
    end

    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    checkOutput("mem_read_cycles", 32'(rd_cnt), 32'(exp_rd));
    checkOutput("mem_write_cycles", 32'(wr_cnt), 32'(exp_wr));
    for (int i = 0; i < NBITS; i++)
      checkOutput($sformatf("mem_bit%0d", i), 32'(mem_bits[i]), 32'(ref_bits[i]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
